// File: rtl/sr_hazard_if.sv
// sr_hazard_if: decode-side operand, forwarding and branch signals of the hazard controller.
interface sr_hazard_if #(parameter int XLEN = 32, parameter int FWD_STAGES = 2);
    logic [4:0]                 rs1_i, rs2_i;
    logic [XLEN-1:0]            rd1_i, rd2_i;
    logic [FWD_STAGES-1:0]      fwd_we_i;
    logic [5*FWD_STAGES-1:0]    fwd_rd_i;
    logic [XLEN*FWD_STAGES-1:0] fwd_data_i;
    logic [FWD_STAGES-1:0]      fwd_pending_i;
    logic                       branch_i, br_valid_i, br_taken_i;
    logic [XLEN-1:0]            br_target_i;
    logic [XLEN-1:0]            pc_o;
    logic                       freeze_o, bubble_o;
    logic [XLEN-1:0]            srcA_o, srcB_o;
    logic [31:0]                stall_cnt_o;
    logic                       err_o;
    modport master (
        output rs1_i, rs2_i, rd1_i, rd2_i, fwd_we_i, fwd_rd_i, fwd_data_i, fwd_pending_i,
               branch_i, br_valid_i, br_taken_i, br_target_i,
        input  pc_o, freeze_o, bubble_o, srcA_o, srcB_o, stall_cnt_o, err_o
    );
    modport slave (
        input  rs1_i, rs2_i, rd1_i, rd2_i, fwd_we_i, fwd_rd_i, fwd_data_i, fwd_pending_i,
               branch_i, br_valid_i, br_taken_i, br_target_i,
        output pc_o, freeze_o, bubble_o, srcA_o, srcB_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/sr_hazard_ctrl.sv
// sr_hazard_ctrl: operand forwarding, load-use stall and branch freeze for the pipelined core.
module sr_hazard_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              FWD_STAGES = 2,
    parameter int              BRANCH_LAT = 3,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic        clk,
    input logic        rst_n,
    sr_hazard_if.slave bus
);
    localparam int CW = BRANCH_LAT > 1 ? $clog2(BRANCH_LAT) : 1;
    typedef enum logic {RUN, WAIT} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] pc, src_a, src_b;
    logic [31:0]     stall_cnt;
    logic            err, pend_a, pend_b, dstall, freeze, wait_st;
    // Walk from the farthest stage down so the nearest match overrides.
    always_comb begin
        src_a  = bus.rd1_i;
        src_b  = bus.rd2_i;
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (bus.fwd_we_i[k] && bus.fwd_rd_i[5*k +: 5] == bus.rs1_i && bus.rs1_i != 5'd0) begin
                src_a  = bus.fwd_data_i[XLEN*k +: XLEN];
                pend_a = bus.fwd_pending_i[k];
            end
            if (bus.fwd_we_i[k] && bus.fwd_rd_i[5*k +: 5] == bus.rs2_i && bus.rs2_i != 5'd0) begin
                src_b  = bus.fwd_data_i[XLEN*k +: XLEN];
                pend_b = bus.fwd_pending_i[k];
            end
        end
    end
    assign wait_st = state == WAIT;
    assign dstall  = pend_a | pend_b;
    assign freeze  = wait_st | dstall | bus.branch_i;
    assign bus.freeze_o    = freeze;
    assign bus.bubble_o    = !wait_st & dstall;
    assign bus.srcA_o      = src_a;
    assign bus.srcB_o      = src_b;
    assign bus.pc_o        = pc;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.err_o       = err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            pc        <= RESET_PC;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (state == RUN) begin
                if (!dstall && bus.branch_i) begin
                    state <= WAIT;
                    cnt   <= '0;
                end else if (!dstall) pc <= pc + XLEN'(4);
            end else if (bus.br_valid_i) begin
                state <= RUN;
                if (bus.br_taken_i) pc <= bus.br_target_i;
            end else if (cnt == CW'(BRANCH_LAT - 1)) begin
                state <= RUN;
                err   <= 1'b1;
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_sr_hazard_ctrl.sv
// tb_sr_hazard_ctrl: directed scenarios plus randomized run against a cycle-level behavioural model.
module tb_sr_hazard_ctrl;
    localparam int XLEN = 32, NF = 2, LAT = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;
    sr_hazard_if #(.XLEN(XLEN), .FWD_STAGES(NF)) bus();
    sr_hazard_ctrl #(.XLEN(XLEN), .FWD_STAGES(NF), .BRANCH_LAT(LAT), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rs1_i = 0; bus.rs2_i = 0; bus.rd1_i = 32'h1111; bus.rd2_i = 32'h2222;
        bus.fwd_we_i = 0; bus.fwd_rd_i = 0; bus.fwd_data_i = 0; bus.fwd_pending_i = 0;
        bus.branch_i = 0; bus.br_valid_i = 0; bus.br_taken_i = 0; bus.br_target_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (bus.pc_o !== 32'h0 || bus.freeze_o !== 1'b0) begin errors++; $display("FAIL rst_hold pc=%h frz=%b exp 0/0", bus.pc_o, bus.freeze_o); end
        checks++; if (bus.stall_cnt_o !== 32'h0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_regs stall=%h err=%b exp 0/0", bus.stall_cnt_o, bus.err_o); end
        rst_n = 1'b1;
        #1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (bus.pc_o !== 32'(4 * i) || bus.freeze_o !== 1'b0) begin errors++; $display("FAIL rst_pc%0d pc=%h frz=%b exp %h/0", i, bus.pc_o, bus.freeze_o, 32'(4 * i)); end
        end
    endtask

    task automatic test_forward();
        idle();
        bus.rs1_i = 5; bus.rs2_i = 7; bus.fwd_we_i = 2'b11; bus.fwd_rd_i = {5'd5, 5'd5};
        bus.fwd_data_i = {32'hBBBB, 32'hAAAA};
        #1;
        checks++; if (bus.srcA_o !== 32'hAAAA) begin errors++; $display("FAIL fwd_prio got %h exp %h", bus.srcA_o, 32'hAAAA); end
        checks++; if (bus.srcB_o !== 32'h2222) begin errors++; $display("FAIL fwd_nomatch got %h exp %h", bus.srcB_o, 32'h2222); end
        bus.fwd_we_i = 2'b10;
        #1;
        checks++; if (bus.srcA_o !== 32'hBBBB) begin errors++; $display("FAIL fwd_stage1 got %h exp %h", bus.srcA_o, 32'hBBBB); end
        bus.rs1_i = 0; bus.fwd_we_i = 2'b11; bus.fwd_rd_i = 0;
        #1;
        checks++; if (bus.srcA_o !== 32'h1111) begin errors++; $display("FAIL fwd_x0 got %h exp %h", bus.srcA_o, 32'h1111); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.rs2_i = 3; bus.fwd_we_i = 2'b01; bus.fwd_rd_i = {5'd0, 5'd3}; bus.fwd_pending_i = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.freeze_o !== 1'b1 || bus.bubble_o !== 1'b1 || bus.pc_o !== 32'h0) begin errors++; $display("FAIL lu_stall%0d frz=%b bub=%b pc=%h exp 1/1/0", i, bus.freeze_o, bus.bubble_o, bus.pc_o); end
            tick();
        end
        bus.fwd_pending_i = 2'b00;
        #1;
        checks++; if (bus.freeze_o !== 1'b0 || bus.bubble_o !== 1'b0 || bus.pc_o !== 32'h0) begin errors++; $display("FAIL lu_release frz=%b bub=%b pc=%h exp 0/0/0", bus.freeze_o, bus.bubble_o, bus.pc_o); end
        checks++; if (bus.stall_cnt_o !== 32'd2) begin errors++; $display("FAIL lu_cnt got %0d exp 2", bus.stall_cnt_o); end
        tick();
        checks++; if (bus.pc_o !== 32'h4) begin errors++; $display("FAIL lu_adv got %h exp 4", bus.pc_o); end
        idle();
    endtask

    task automatic test_branch(input bit taken);
        do_reset();
        repeat (4) tick();
        bus.branch_i = 1;
        #1;
        checks++; if (bus.freeze_o !== 1'b1 || bus.bubble_o !== 1'b0 || bus.pc_o !== 32'h10) begin errors++; $display("FAIL br_T frz=%b bub=%b pc=%h exp 1/0/10", bus.freeze_o, bus.bubble_o, bus.pc_o); end
        tick();
        bus.branch_i = 0;
        #1;
        checks++; if (bus.freeze_o !== 1'b1 || bus.pc_o !== 32'h10) begin errors++; $display("FAIL br_T1 frz=%b pc=%h exp 1/10", bus.freeze_o, bus.pc_o); end
        tick();
        bus.br_valid_i = 1; bus.br_taken_i = taken; bus.br_target_i = 32'h40;
        #1;
        checks++; if (bus.freeze_o !== 1'b1) begin errors++; $display("FAIL br_T2 frz=%b exp 1", bus.freeze_o); end
        tick();
        idle();
        #1;
        checks++; if (bus.pc_o !== (taken ? 32'h40 : 32'h10) || bus.freeze_o !== 1'b0) begin errors++; $display("FAIL br_T3 t=%b pc=%h frz=%b exp %h/0", taken, bus.pc_o, bus.freeze_o, taken ? 32'h40 : 32'h10); end
        tick();
        checks++; if (bus.pc_o !== (taken ? 32'h44 : 32'h14)) begin errors++; $display("FAIL br_T4 t=%b pc=%h exp %h", taken, bus.pc_o, taken ? 32'h44 : 32'h14); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.branch_i = 1;
        tick();
        bus.branch_i = 0;
        for (int i = 1; i <= LAT; i++) begin
            #1;
            checks++; if (bus.freeze_o !== 1'b1 || bus.err_o !== 1'b0) begin errors++; $display("FAIL to_wait%0d frz=%b err=%b exp 1/0", i, bus.freeze_o, bus.err_o); end
            tick();
        end
        checks++; if (bus.err_o !== 1'b1 || bus.freeze_o !== 1'b0 || bus.pc_o !== 32'h0) begin errors++; $display("FAIL to_expire err=%b frz=%b pc=%h exp 1/0/0", bus.err_o, bus.freeze_o, bus.pc_o); end
        tick();
        checks++; if (bus.pc_o !== 32'h4 || bus.err_o !== 1'b1) begin errors++; $display("FAIL to_resume pc=%h err=%b exp 4/1", bus.pc_o, bus.err_o); end
        bus.branch_i = 1;
        tick();
        bus.branch_i = 0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.freeze_o !== 1'b0) begin errors++; $display("FAIL to_rst err=%b pc=%h frz=%b exp 0/0/0", bus.err_o, bus.pc_o, bus.freeze_o); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.pc_o !== 32'h4) begin errors++; $display("FAIL to_rst_run pc=%h exp 4", bus.pc_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.branch_i = 1; bus.rs1_i = 9; bus.fwd_we_i = 2'b10; bus.fwd_rd_i = {5'd9, 5'd0}; bus.fwd_pending_i = 2'b10;
        #1;
        checks++; if (bus.freeze_o !== 1'b1 || bus.bubble_o !== 1'b1) begin errors++; $display("FAIL sim_stall frz=%b bub=%b exp 1/1", bus.freeze_o, bus.bubble_o); end
        tick();
        bus.fwd_pending_i = 2'b00;
        #1;
        checks++; if (bus.freeze_o !== 1'b1 || bus.bubble_o !== 1'b0 || bus.pc_o !== 32'h0) begin errors++; $display("FAIL sim_branch frz=%b bub=%b pc=%h exp 1/0/0", bus.freeze_o, bus.bubble_o, bus.pc_o); end
        tick();
        bus.branch_i = 0; bus.fwd_pending_i = 2'b10;
        #1;
        checks++; if (bus.freeze_o !== 1'b1 || bus.bubble_o !== 1'b0) begin errors++; $display("FAIL sim_wait frz=%b bub=%b exp 1/0", bus.freeze_o, bus.bubble_o); end
        bus.br_valid_i = 1;
        tick();
        idle();
        #1;
        checks++; if (bus.freeze_o !== 1'b0 || bus.pc_o !== 32'h0) begin errors++; $display("FAIL sim_done frz=%b pc=%h exp 0/0", bus.freeze_o, bus.pc_o); end
    endtask

    function automatic void ref_operand(input logic [4:0] rs, input logic [31:0] dflt,
                                        output logic [31:0] val, output bit pend);
        val = dflt;
        pend = 0;
        if (rs == 0) return;
        for (int k = 0; k < NF; k++)
            if (bus.fwd_we_i[k] && bus.fwd_rd_i[5*k +: 5] == rs) begin
                val = bus.fwd_data_i[32*k +: 32];
                pend = bus.fwd_pending_i[k];
                return;
            end
    endfunction

    task automatic test_random();
        longint m_pc = 0, m_stall = 0;
        bit m_err = 0, waiting = 0, stall, efrz, ebub, pa, pb;
        int t_in_wait = 0;
        logic [31:0] ea, eb;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.rs1_i = 5'($urandom_range(0, 3)); bus.rs2_i = 5'($urandom_range(0, 3));
            bus.rd1_i = $urandom; bus.rd2_i = $urandom;
            bus.fwd_we_i = 2'($urandom); bus.fwd_rd_i = 10'($urandom_range(0, 1023) & 10'b0001100011);
            bus.fwd_data_i = {$urandom, $urandom};
            bus.fwd_pending_i = {2'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            bus.branch_i = $urandom_range(0, 4) == 0; bus.br_valid_i = $urandom_range(0, 3) == 0;
            bus.br_taken_i = 1'($urandom); bus.br_target_i = $urandom & 32'hFFFFFFFC;
            #1;
            ref_operand(bus.rs1_i, bus.rd1_i, ea, pa);
            ref_operand(bus.rs2_i, bus.rd2_i, eb, pb);
            stall = !waiting && (pa || pb);
            efrz = waiting || pa || pb || bus.branch_i;
            ebub = stall;
            checks++; if (bus.srcA_o !== ea || bus.srcB_o !== eb) begin errors++; $display("FAIL rnd_src c=%0d a=%h b=%h exp %h/%h", c, bus.srcA_o, bus.srcB_o, ea, eb); end
            checks++; if (bus.freeze_o !== efrz || bus.bubble_o !== ebub) begin errors++; $display("FAIL rnd_ctl c=%0d frz=%b bub=%b exp %b/%b", c, bus.freeze_o, bus.bubble_o, efrz, ebub); end
            checks++; if (bus.pc_o !== 32'(m_pc) || bus.err_o !== m_err || bus.stall_cnt_o !== 32'(m_stall)) begin errors++; $display("FAIL rnd_state c=%0d pc=%h err=%b cnt=%0d exp %h/%b/%0d", c, bus.pc_o, bus.err_o, bus.stall_cnt_o, 32'(m_pc), m_err, 32'(m_stall)); end
            if (efrz && m_stall < 64'hFFFFFFFF) m_stall++;
            if (!waiting) begin
                if (!stall && bus.branch_i) begin waiting = 1; t_in_wait = 1; end
                else if (!stall) m_pc = (m_pc + 4) % (64'd1 << 32);
            end else if (bus.br_valid_i) begin
                waiting = 0;
                if (bus.br_taken_i) m_pc = bus.br_target_i;
            end else if (t_in_wait == LAT) begin
                waiting = 0;
                m_err = 1;
            end else t_in_wait++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch(1'b1);
        test_branch(1'b0);
        test_timeout();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
